// File: rtl/voq_scheduler.sv
// Virtual-output-queue scheduler for a 4x4 switch.
// Each round visits the four ingresses one per cycle, starting from a rotating
// first ingress, and gives each one at most one free egress. The choice comes
// either from a per-ingress round-robin pointer or from a shared priority list.
module voq_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        policy,
  input  logic [7:0]  prio,
  input  logic [15:0] voq_empty,
  output logic        busy,
  output logic        sched_valid,
  output logic [3:0]  sched_grant,
  output logic [7:0]  sched_egress
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state;
  logic [15:0] empty_snap;
  logic        policy_snap;
  logic [7:0]  prio_snap;
  logic [3:0]  picked;
  logic [1:0]  k;
  logic [1:0]  first_ing;
  logic [1:0]  sp [4];

  logic [1:0]  cur_ing;
  logic [3:0]  cur_empty;
  logic [1:0]  sp_cur;
  logic [1:0]  cand0, cand1, cand2, cand3;
  logic        hit;
  logic [1:0]  hit_egress;

  // An egress can be taken only if this ingress has traffic for it and no
  // earlier ingress in the round already claimed it.
  function automatic logic eligible(input logic [1:0] j, input logic [3:0] emp,
                                    input logic [3:0] pk);
    return !emp[j] && !pk[j];
  endfunction

  // Scan order wraps naturally in 2 bits.
  assign cur_ing = first_ing + k;

  // Candidate list for the ingress under scan, then first eligible wins.
  always_comb begin
    cur_empty  = empty_snap[{cur_ing, 2'b00} +: 4];
    sp_cur     = sp[cur_ing];
    cand0      = policy_snap ? prio_snap[7:6] : sp_cur;
    cand1      = policy_snap ? prio_snap[5:4] : sp_cur + 2'd1;
    cand2      = policy_snap ? prio_snap[3:2] : sp_cur + 2'd2;
    cand3      = policy_snap ? prio_snap[1:0] : sp_cur + 2'd3;
    hit        = 1'b1;
    hit_egress = cand0;
    if (eligible(cand0, cur_empty, picked)) begin
      hit_egress = cand0;
    end else if (eligible(cand1, cur_empty, picked)) begin
      hit_egress = cand1;
    end else if (eligible(cand2, cur_empty, picked)) begin
      hit_egress = cand2;
    end else if (eligible(cand3, cur_empty, picked)) begin
      hit_egress = cand3;
    end else begin
      hit        = 1'b0;
      hit_egress = 2'd0;
    end
  end

  // Round inputs are frozen at acceptance so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      empty_snap  <= voq_empty;
      policy_snap <= policy;
      prio_snap   <= prio;
    end
  end

  // Round control, per-ingress results and pointer rotation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      sched_valid  <= 1'b0;
      sched_grant  <= 4'd0;
      sched_egress <= 8'd0;
      picked       <= 4'd0;
      k            <= 2'd0;
      first_ing    <= 2'd0;
      for (int i = 0; i < 4; i++) sp[i] <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            picked       <= 4'd0;
            sched_grant  <= 4'd0;
            sched_egress <= 8'd0;
            k            <= 2'd0;
            busy         <= 1'b1;
            state        <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            sched_grant[cur_ing]                  <= 1'b1;
            sched_egress[{cur_ing, 1'b0} +: 2]    <= hit_egress;
            picked[hit_egress]                    <= 1'b1;
          end else begin
            sched_grant[cur_ing]                  <= 1'b0;
            sched_egress[{cur_ing, 1'b0} +: 2]    <= 2'd0;
          end
          k <= k + 2'd1;
          if (k == 2'd3) begin
            sched_valid <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          sched_valid <= 1'b0;
          busy        <= 1'b0;
          first_ing   <= first_ing + 2'd1;
          for (int i = 0; i < 4; i++) begin
            if (sched_grant[i]) sp[i] <= sched_egress[2*i +: 2] + 2'd1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
